uart_tx_arbiter: RTL and testbench

Two-port transmit arbiter and serializer that shares the SoC's single `ser_tx` line between two byte producers (port 0: CPU UART register path; port 1: debug/trace source). It accepts bytes via valid/ready handshakes, grants the line round-robin per frame, and serializes 8N1 frames with a fixed clock divider. It sits between the producers and the top-level `ser_tx` pin, so the bench's serial monitor sees one clean, non-interleaved stream.

---
 rtl/uart_tx_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one serial transmit line between two byte producers. Each producer
// offers a byte over a valid/ready handshake. The line is granted per frame,
// round-robin on ties. The accepted byte is sent as an 8N1 frame with CLKDIV
// clock cycles per bit.
//
// Optional feature: define UART_TX_ARB_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit. This makes each frame 11 bit times
// long instead of 10.
//
// Ports:
//   clk          system clock, rising edge
//   resetn       asynchronous active-low reset
//   req0_valid   port 0 has a byte (CPU UART register path)
//   req0_data    port 0 byte, held stable while req0_valid is high
//   req0_ready   port 0 byte is accepted on this edge if req0_valid is high
//   req1_valid   port 1 has a byte (debug/trace source)
//   req1_data    port 1 byte, held stable while req1_valid is high
//   req1_ready   port 1 byte is accepted on this edge if req1_valid is high
//   ser_tx       serial output, idle high, driven from a flop
//   busy         a frame is in progress
//   grant        port that owns the current or most recent frame
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int CLKDIV = 6
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       ser_tx,
    output logic       busy,
    output logic       grant
);

    localparam int CNT_W = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLKDIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_ARB_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] div_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift_reg;
    logic             last_grant;
`ifdef UART_TX_ARB_PARITY_EN
    logic             parity_bit;
`endif

    logic       slot_open;
    logic       winner;
    logic       accept;
    logic [7:0] win_data;

    // A new byte can be taken while idle, or in the last cycle of the stop
    // bit. Taking it in the last stop cycle gives back-to-back frames with
    // no idle gap.
    always_comb begin
        slot_open = (state == IDLE) || ((state == STOP) && (div_cnt == '0));
        if (req0_valid && req1_valid) begin
            winner = ~last_grant;
        end else begin
            winner = req1_valid;
        end
        req0_ready = slot_open & req0_valid & ~winner;
        req1_ready = slot_open & req1_valid & winner;
        accept     = req0_ready | req1_ready;
        win_data   = winner ? req1_data : req0_data;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            div_cnt    <= '0;
            bit_cnt    <= 3'd0;
            shift_reg  <= 8'h00;
            last_grant <= 1'b1;
            grant      <= 1'b0;
            ser_tx     <= 1'b1;
            busy       <= 1'b0;
`ifdef UART_TX_ARB_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else if (accept) begin
            // Accept can only happen in IDLE or in the final STOP cycle.
            // Both cases start a fresh frame with the start bit on this edge.
            state      <= START;
            div_cnt    <= DIV_LAST;
            bit_cnt    <= 3'd0;
            shift_reg  <= win_data;
            last_grant <= winner;
            grant      <= winner;
            ser_tx     <= 1'b0;
            busy       <= 1'b1;
`ifdef UART_TX_ARB_PARITY_EN
            parity_bit <= ^win_data;
`endif
        end else begin
            case (state)
                IDLE: begin
                    ser_tx <= 1'b1;
                    busy   <= 1'b0;
                end
                START: begin
                    if (div_cnt == '0) begin
                        state     <= DATA;
                        div_cnt   <= DIV_LAST;
                        ser_tx    <= shift_reg[0];
                        shift_reg <= {1'b0, shift_reg[7:1]};
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (div_cnt == '0) begin
                        div_cnt <= DIV_LAST;
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= 3'd0;
`ifdef UART_TX_ARB_PARITY_EN
                            state  <= PARITY;
                            ser_tx <= parity_bit;
`else
                            state  <= STOP;
                            ser_tx <= 1'b1;
`endif
                        end else begin
                            bit_cnt   <= bit_cnt + 3'd1;
                            ser_tx    <= shift_reg[0];
                            shift_reg <= {1'b0, shift_reg[7:1]};
                        end
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
`ifdef UART_TX_ARB_PARITY_EN
                PARITY: begin
                    if (div_cnt == '0) begin
                        state   <= STOP;
                        div_cnt <= DIV_LAST;
                        ser_tx  <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
`endif
                STOP: begin
                    // Without an accept on the last stop cycle, go back to idle.
                    if (div_cnt == '0) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        ser_tx <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    ser_tx <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int D = 6;
`ifdef UART_TX_ARB_PARITY_EN
    localparam int NSLOT = 11;
`else
    localparam int NSLOT = 10;
`endif
    localparam int FL = NSLOT * D;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       req0_valid = 1'b0;
    logic [7:0] req0_data = 8'h00;
    logic       req0_ready;
    logic       req1_valid = 1'b0;
    logic [7:0] req1_data = 8'h00;
    logic       req1_ready;
    logic       ser_tx;
    logic       busy;
    logic       grant;

    uart_tx_arbiter #(.CLKDIV(D)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .ser_tx     (ser_tx),
        .busy       (busy),
        .grant      (grant)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is a timeline of FL cycles. The model keeps
    // the remaining cycles and the position in the frame's bit-slot list.
    int         m_rem;
    int         m_pos;
    logic       m_slots [0:10];
    logic       m_grant;
    logic       m_last;
    logic [7:0] exp_q [$];
    logic       acc;
    logic       acc_port;
    logic [7:0] acc_byte;
    logic       mw, mcan, me0, me1;
    int         both_ready = 0;
    int         rdy0_count = 0;

    task automatic model_reset();
        m_rem   = 0;
        m_pos   = 0;
        m_grant = 1'b0;
        m_last  = 1'b1;
        acc     = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_start(input logic port, input logic [7:0] b);
        m_slots[0] = 1'b0;
        for (int k = 0; k < 8; k++) m_slots[k+1] = b[k];
`ifdef UART_TX_ARB_PARITY_EN
        m_slots[9] = ^b;
`endif
        m_slots[NSLOT-1] = 1'b1;
        m_rem   = FL;
        m_pos   = 0;
        m_grant = port;
        m_last  = port;
        exp_q.push_back(b);
    endtask

    // Compare process. Ready is checked at the falling edge, while the inputs
    // are stable. Registered outputs are checked just after the rising edge.
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (!resetn) model_reset();
            mcan = (m_rem <= 1);
            mw   = (req0_valid && req1_valid) ? ~m_last : req1_valid;
            me0  = mcan && req0_valid && !mw;
            me1  = mcan && req1_valid && mw;
            check1("req0_ready", req0_ready, me0);
            check1("req1_ready", req1_ready, me1);
            if (req0_ready && req1_ready) both_ready++;
            if (req0_ready) rdy0_count++;
            acc      = me0 || me1;
            acc_port = mw;
            acc_byte = mw ? req1_data : req0_data;
            @(posedge clk);
            #1;
            if (!resetn) begin
                model_reset();
            end else if (acc) begin
                model_start(acc_port, acc_byte);
            end else if (m_rem > 0) begin
                m_rem--;
                m_pos++;
            end
            check1("ser_tx", ser_tx, (m_rem > 0) ? m_slots[m_pos / D] : 1'b1);
            check1("busy", busy, m_rem > 0);
            check1("grant", grant, m_grant);
        end
    end

    // Serial monitor: decodes frames at mid-bit and checks them against the
    // expected byte order. It also measures how long busy stays high.
    logic [7:0] mon_bytes [$];
    int         mon_starts [$];
    int         cyc = 0;
    int         mon_cnt = 0;
    int         slot;
    bit         mon_active = 0;
    logic [7:0] mon_byte = 8'h00;
    logic       mon_parity = 1'b0;
    int         busy_run = 0;
    int         last_busy_run = 0;

    initial begin
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            if (!resetn) begin
                mon_active = 0;
                busy_run   = 0;
            end else begin
                if (busy) begin
                    busy_run++;
                end else if (busy_run > 0) begin
                    last_busy_run = busy_run;
                    busy_run      = 0;
                end
                if (!mon_active) begin
                    if (ser_tx == 1'b0) begin
                        mon_active = 1;
                        mon_cnt    = 0;
                        mon_starts.push_back(cyc);
                    end
                end else begin
                    mon_cnt++;
                    if (mon_cnt % D == D / 2) begin
                        slot = mon_cnt / D;
                        if (slot >= 1 && slot <= 8) mon_byte[3'(slot - 1)] = ser_tx;
`ifdef UART_TX_ARB_PARITY_EN
                        if (slot == 9) mon_parity = ser_tx;
`endif
                        if (slot == NSLOT - 1) check1("stop_bit", ser_tx, 1'b1);
                    end
                    if (mon_cnt == FL - 1) begin
                        mon_active = 0;
                        mon_bytes.push_back(mon_byte);
`ifdef UART_TX_ARB_PARITY_EN
                        check1("parity_bit", mon_parity, ^mon_byte);
`endif
                        if (exp_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL frame_unexpected: got byte 0x%0h expected no frame at %0t", mon_byte, $time);
                        end else begin
                            check32("frame_byte", 32'(mon_byte), 32'(exp_q.pop_front()));
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic clear_mon();
        mon_bytes.delete();
        mon_starts.delete();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        resetn     = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick(3);
        #3;
        resetn = 1'b1;
        clear_mon();
    endtask

    logic [10:0] pat;
    logic        r0, r1;

    initial begin
        // Reset state
        tick(3);
        #1;
        check1("reset_ser_tx", ser_tx, 1'b1);
        check1("reset_busy", busy, 1'b0);
        check1("reset_grant", grant, 1'b0);
        #2;
        resetn = 1'b1;
        tick(2);

        // Single byte 0x55 from port 0
`ifdef UART_TX_ARB_PARITY_EN
        pat = 11'b10010101010;
`else
        pat = 11'b01010101010;
`endif
        clear_mon();
        @(posedge clk); #2;
        req0_data  = 8'h55;
        req0_valid = 1'b1;
        @(negedge clk);
        check1("t1_req0_ready", req0_ready, 1'b1);
        @(posedge clk); #2;
        req0_valid = 1'b0;
        tick(D / 2); #1;
        for (int s = 0; s < NSLOT; s++) begin
            check1("t1_slot", ser_tx, pat[s]);
            tick(D); #1;
        end
        tick(10);
        check32("t1_busy_len", 32'(last_busy_run), 32'(FL));
        check1("t1_grant", grant, 1'b0);
        check32("t1_nbytes", 32'(mon_bytes.size()), 32'd1);
        check32("t1_byte", 32'(mon_bytes[0]), 32'h55);

        // Both ports contending: strict alternation, first tie to port 0
        do_reset();
        @(posedge clk); #2;
        req0_data  = 8'h41;
        req1_data  = 8'h42;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        @(posedge clk);
        tick(3 * FL); #2;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick(FL + 10);
        check32("t2_nbytes", 32'(mon_bytes.size()), 32'd4);
        check32("t2_byte0", 32'(mon_bytes[0]), 32'h41);
        check32("t2_byte1", 32'(mon_bytes[1]), 32'h42);
        check32("t2_byte2", 32'(mon_bytes[2]), 32'h41);
        check32("t2_byte3", 32'(mon_bytes[3]), 32'h42);
        for (int i = 1; i < 4; i++)
            check32("t2_spacing", 32'(mon_starts[i] - mon_starts[i-1]), 32'(FL));
        check32("t2_both_ready", 32'(both_ready), 32'd0);

        // Port 1 streams 0x00 then 0xFF with valid held high
        clear_mon();
        @(posedge clk); #2;
        req1_data  = 8'h00;
        req1_valid = 1'b1;
        @(posedge clk); #2;
        req1_data = 8'hFF;
        tick(FL); #2;
        req1_valid = 1'b0;
        tick(FL + 10);
        check32("t3_nbytes", 32'(mon_bytes.size()), 32'd2);
        check32("t3_byte0", 32'(mon_bytes[0]), 32'h00);
        check32("t3_byte1", 32'(mon_bytes[1]), 32'hFF);
        check32("t3_spacing", 32'(mon_starts[1] - mon_starts[0]), 32'(FL));
        check32("t3_busy_len", 32'(last_busy_run), 32'(2 * FL));

        // Reset 25 cycles into a 0xA5 frame
        do_reset();
        @(posedge clk); #2;
        req0_data  = 8'hA5;
        req0_valid = 1'b1;
        @(posedge clk);
        tick(24); #1;
        check1("t4_pre_ser_tx", ser_tx, 1'b0);
        #2;
        resetn     = 1'b0;
        req1_data  = 8'h3C;
        req1_valid = 1'b1;
        #1;
        check1("t4_async_ser_tx", ser_tx, 1'b1);
        check1("t4_async_busy", busy, 1'b0);
        tick(3); #3;
        resetn = 1'b1;
        clear_mon();
        @(posedge clk); #1;
        check1("t4_tie_grant", grant, 1'b0);
        #1;
        req0_valid = 1'b0;
        tick(FL); #2;
        req1_valid = 1'b0;
        tick(FL + 10);
        check32("t4_nbytes", 32'(mon_bytes.size()), 32'd2);
        check32("t4_byte0", 32'(mon_bytes[0]), 32'hA5);
        check32("t4_byte1", 32'(mon_bytes[1]), 32'h3C);

        // Parity slot and stop slot timing (0x07, then 0x03)
        clear_mon();
        @(posedge clk); #2;
        req0_data  = 8'h07;
        req0_valid = 1'b1;
        @(posedge clk); #2;
        req0_valid = 1'b0;
        tick(55); #1;
        check1("t5_07_bit9", ser_tx, 1'b1);
        tick(6); #1;
        check1("t5_07_slot10", ser_tx, 1'b1);
`ifdef UART_TX_ARB_PARITY_EN
        check1("t5_07_busy", busy, 1'b1);
`else
        check1("t5_07_busy", busy, 1'b0);
`endif
        tick(FL);
        @(posedge clk); #2;
        req0_data  = 8'h03;
        req0_valid = 1'b1;
        @(posedge clk); #2;
        req0_valid = 1'b0;
        tick(55); #1;
`ifdef UART_TX_ARB_PARITY_EN
        check1("t5_03_parity", ser_tx, 1'b0);
`else
        check1("t5_03_stop", ser_tx, 1'b1);
`endif
        tick(FL);

        // Port 0 offers then withdraws while a port-1 frame is on the line
        clear_mon();
        @(posedge clk); #2;
        req1_data  = 8'h99;
        req1_valid = 1'b1;
        @(posedge clk); #2;
        req1_valid = 1'b0;
        r0 = 1'b0;
        tick(10); #2;
        req0_data  = 8'h11;
        req0_valid = 1'b1;
        both_ready = 0;
        rdy0_count = 0;
        tick(20); #2;
        req0_valid = 1'b0;
        check32("t6_rdy0_pulses", 32'(rdy0_count), 32'd0);
        tick(FL);
        check32("t6_nbytes", 32'(mon_bytes.size()), 32'd1);
        check32("t6_byte0", 32'(mon_bytes[0]), 32'h99);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            r0 = req0_ready;
            r1 = req1_ready;
            @(posedge clk); #2;
            if (req0_valid && r0) begin
                req0_valid = ($urandom_range(0, 3) != 0);
                req0_data  = 8'($urandom);
            end else if (req0_valid) begin
                if ($urandom_range(0, 15) == 0) req0_valid = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                req0_valid = 1'b1;
                req0_data  = 8'($urandom);
            end
            if (req1_valid && r1) begin
                req1_valid = ($urandom_range(0, 3) != 0);
                req1_data  = 8'($urandom);
            end else if (req1_valid) begin
                if ($urandom_range(0, 15) == 0) req1_valid = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                req1_valid = 1'b1;
                req1_data  = 8'($urandom);
            end
        end
        @(posedge clk); #2;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick(FL + 10);
        check32("rand_drained", 32'(exp_q.size()), 32'd0);
        check32("rand_both_ready", 32'(both_ready), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
